lzy_down_counter: RTL and testbench



---
 rtl/lzy_down_counter_if.sv | 24 ++
 rtl/lzy_down_counter.sv | 61 ++++++
 tb/tb_lzy_down_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lzy_down_counter_if.sv
// lzy_down_counter_if: control, data and status signals of the down-counter
interface lzy_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  CEP;
    logic                  CET;
    logic                  PE;
    logic                  ARE;
    logic [4*DIGITS-1:0]   D;
    logic [4*DIGITS-1:0]   Q;
    logic                  TC;
    logic                  BO;
    logic                  ZERO;

    modport master (
        output CEP, CET, PE, ARE, D,
        input  Q, TC, BO, ZERO
    );

    modport slave (
        input  CEP, CET, PE, ARE, D,
        output Q, TC, BO, ZERO
    );
endinterface

// File: rtl/lzy_down_counter.sv
// lzy_down_counter: presettable cascadable BCD/binary down-counter with auto-reload and borrow pulse
module lzy_down_counter #(
    parameter int DIGITS = 2,
    parameter int BCD    = 1
) (
    input logic              Clk,
    input logic              MR,
    lzy_down_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [3:0] MAX_DIG = (BCD != 0) ? 4'd9 : 4'd15;

    logic [W-1:0]    q;
    logic [W-1:0]    rld;
    logic [W-1:0]    q_dec;
    logic [W-1:0]    max_val;
    logic [DIGITS:0] borrow;
    logic            bo;
    logic            zero;
    logic            count;

    assign borrow[0] = 1'b1;

    // A digit decrements only while every lower digit sits at 0; illegal BCD
    // digits are nonzero, so they step down without ever borrowing.
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            logic [3:0] dig;
            assign dig              = q[4*i +: 4];
            assign borrow[i+1]      = borrow[i] & (dig == 4'd0);
            assign q_dec[4*i +: 4]  = borrow[i] ? ((dig == 4'd0) ? MAX_DIG : dig - 4'd1) : dig;
            assign max_val[4*i +: 4] = MAX_DIG;
        end
    endgenerate

    assign zero     = (q == '0);
    assign count    = bus.CEP & bus.CET;
    assign bus.Q    = q;
    assign bus.ZERO = zero;
    assign bus.TC   = bus.CET & zero;
    assign bus.BO   = bo;

    // Priority: reset, load, count (with underflow reload), hold.
    always_ff @(posedge Clk) begin
        if (MR) begin
            q   <= '0;
            rld <= '0;
            bo  <= 1'b0;
        end else if (!bus.PE) begin
            q   <= bus.D;
            rld <= bus.D;
            bo  <= 1'b0;
        end else if (count) begin
            q   <= zero ? (bus.ARE ? rld : max_val) : q_dec;
            bo  <= zero;
        end else begin
            bo  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lzy_down_counter.sv
// tb_lzy_down_counter: directed self-checking bench for BCD and binary down-counters
module tb_lzy_down_counter;
    logic Clk = 1'b0;
    logic MR  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lzy_down_counter_if #(.DIGITS(2)) ia ();
    lzy_down_counter_if #(.DIGITS(2)) ib ();

    lzy_down_counter #(.DIGITS(2), .BCD(1)) dut_bcd (.Clk(Clk), .MR(MR), .bus(ia.slave));
    lzy_down_counter #(.DIGITS(2), .BCD(0)) dut_bin (.Clk(Clk), .MR(MR), .bus(ib.slave));

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] seq_bcd [13] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                                 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
    logic [7:0] seq_are [8]  = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    logic [7:0] seq_bin [3]  = '{8'h00, 8'hFF, 8'hFE};

    initial begin
        ia.CEP = 0; ia.CET = 0; ia.PE = 1; ia.ARE = 0; ia.D = 8'h00;
        ib.CEP = 0; ib.CET = 0; ib.PE = 1; ib.ARE = 0; ib.D = 8'h00;
        MR = 1;
        step();
        MR = 0;
        chk("rst_q", 16'(ia.Q), 16'h00);
        chk("rst_zero", 16'(ia.ZERO), 16'h1);
        chk("rst_tc", 16'(ia.TC), 16'h0);
        chk("rst_bo", 16'(ia.BO), 16'h0);
        chk("rst_bin_q", 16'(ib.Q), 16'h00);
        ia.CET = 1;
        #1;
        chk("rst_tc_cet", 16'(ia.TC), 16'h1);

        ia.D = 8'h12; ia.PE = 0;
        step();
        chk("load12_q", 16'(ia.Q), 16'h12);
        ia.PE = 1; ia.CEP = 1; ia.CET = 1; ia.ARE = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            chk($sformatf("bcd_q%0d", k), 16'(ia.Q), 16'(seq_bcd[k]));
            chk($sformatf("bcd_bo%0d", k), 16'(ia.BO), 16'(k == 12));
            chk($sformatf("bcd_tc%0d", k), 16'(ia.TC), 16'(k == 11));
        end

        ia.D = 8'h03; ia.ARE = 1; ia.PE = 0;
        step();
        chk("load03_q", 16'(ia.Q), 16'h03);
        ia.PE = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("are_q%0d", k), 16'(ia.Q), 16'(seq_are[k]));
            chk($sformatf("are_bo%0d", k), 16'(ia.BO), 16'(k == 3 || k == 7));
        end

        ia.D = 8'h50; ia.ARE = 0; ia.PE = 0;
        step();
        ia.PE = 1;
        step();
        chk("gate_q49", 16'(ia.Q), 16'h49);
        step();
        chk("gate_q48", 16'(ia.Q), 16'h48);
        ia.CEP = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("cep_hold_q%0d", k), 16'(ia.Q), 16'h48);
            chk($sformatf("cep_hold_bo%0d", k), 16'(ia.BO), 16'h0);
        end
        ia.CEP = 1;
        step();
        chk("gate_q47", 16'(ia.Q), 16'h47);
        ia.CET = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("cet_hold_q%0d", k), 16'(ia.Q), 16'h47);
            chk($sformatf("cet_hold_bo%0d", k), 16'(ia.BO), 16'h0);
        end
        ia.D = 8'h01; ia.PE = 0;
        step();
        ia.PE = 1; ia.CET = 1;
        step();
        chk("gate_q00", 16'(ia.Q), 16'h00);
        chk("gate_tc_on", 16'(ia.TC), 16'h1);
        ia.CET = 0;
        #1;
        chk("gate_tc_off", 16'(ia.TC), 16'h0);
        chk("gate_zero", 16'(ia.ZERO), 16'h1);
        step();
        chk("gate_zero_hold_q", 16'(ia.Q), 16'h00);
        chk("gate_zero_hold_bo", 16'(ia.BO), 16'h0);

        ia.CET = 1; ia.D = 8'h0C; ia.PE = 0;
        step();
        chk("prio_load_q", 16'(ia.Q), 16'h0C);
        ia.PE = 1;
        step();
        chk("illegal_q0B", 16'(ia.Q), 16'h0B);
        chk("illegal_bo0B", 16'(ia.BO), 16'h0);
        step();
        chk("illegal_q0A", 16'(ia.Q), 16'h0A);
        step();
        chk("illegal_q09", 16'(ia.Q), 16'h09);
        MR = 1; ia.PE = 0; ia.D = 8'h77;
        step();
        MR = 0; ia.PE = 1; ia.ARE = 1;
        chk("mr_pe_q", 16'(ia.Q), 16'h00);
        chk("mr_pe_bo", 16'(ia.BO), 16'h0);
        step();
        chk("rld0_q_a", 16'(ia.Q), 16'h00);
        chk("rld0_bo_a", 16'(ia.BO), 16'h1);
        step();
        chk("rld0_q_b", 16'(ia.Q), 16'h00);
        chk("rld0_bo_b", 16'(ia.BO), 16'h1);

        ib.D = 8'h01; ib.ARE = 0; ib.PE = 0;
        step();
        chk("bin_load_q", 16'(ib.Q), 16'h01);
        ib.PE = 1; ib.CEP = 1; ib.CET = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bin_q%0d", k), 16'(ib.Q), 16'(seq_bin[k]));
            chk($sformatf("bin_bo%0d", k), 16'(ib.BO), 16'(k == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
